// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate fronting a MEM_BYTES on-chip SRAM.
// Serves byte/halfword/word accesses with little-endian byte lanes and answers
// misaligned, oversized or out-of-range accesses with the two-cycle ERROR response.
// Optional feature macro: AHB_SUB_WAITSTATE_EN inserts WAIT_CYCLES wait states in
// front of every OKAY transfer; without it all OKAY transfers are zero-wait.
module ahb_sram_subordinate #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_BYTES   = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int AW    = $clog2(MEM_BYTES);
   localparam int WORDS = MEM_BYTES / 4;
   localparam int IDX_W = (AW > 2) ? AW - 2 : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [1:0]            size_q, size_d;
   logic                  write_q, write_d;
`ifdef AHB_SUB_WAITSTATE_EN
   logic [3:0]            cnt_q, cnt_d;
`endif

   logic [DATA_WIDTH-1:0] mem [WORDS];

   logic                  sample;
   logic                  bad_access;
   logic [IDX_W-1:0]      idx;
   logic [3:0]            lanes;

   // Burst type and protection carry no meaning for a plain SRAM.
   logic                  unused_ok;
   assign unused_ok = ^{HBURST, HPROT, 4'(WAIT_CYCLES)};

   // Address-phase qualification and access legality, evaluated on the live bus.
   always_comb begin
      sample     = HSEL & HREADY & HTRANS[1];
      bad_access = (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && HADDR[0])
                 || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                 || (HADDR >= ADDR_WIDTH'(MEM_BYTES));
   end

   // Word index and active byte lanes of the transfer currently in its data phase.
   always_comb begin
      idx = IDX_W'(addr_q >> 2);
      case (size_q)
         2'd0:    lanes = 4'b0001 << addr_q[1:0];
         2'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lanes = 4'b1111;
      endcase
   end

   // Next-state, captured address-phase controls and response outputs.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      size_d    = size_q;
      write_d   = write_q;
`ifdef AHB_SUB_WAITSTATE_EN
      cnt_d     = cnt_q;
`endif
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;

      case (state_q)
         S_WAIT: begin
            HREADYOUT = 1'b0;
`ifdef AHB_SUB_WAITSTATE_EN
            if (cnt_q <= 4'd1) begin
               state_d = S_DATA;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
`else
            state_d = S_DATA;
`endif
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = S_ERR2;
         end
         default: begin
            // S_IDLE, S_DATA and S_ERR2 all present HREADYOUT=1, so a new
            // address phase may be accepted in any of them.
            if (state_q == S_ERR2) begin
               HRESP = 1'b1;
            end
            if (sample) begin
               addr_d  = HADDR[AW-1:0];
               size_d  = HSIZE[1:0];
               write_d = HWRITE;
               if (bad_access) begin
                  state_d = S_ERR1;
               end else begin
`ifdef AHB_SUB_WAITSTATE_EN
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
`else
                  state_d = S_DATA;
`endif
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // Read data is driven only while a read completes; the bus mux relies on zero otherwise.
   always_comb begin
      HRDATA = '0;
      if ((state_q == S_DATA) && !write_q) begin
         HRDATA = mem[idx];
      end
   end

   // Control state; reset returns the FSM to idle and drops any pending data phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
`ifdef AHB_SUB_WAITSTATE_EN
         cnt_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
`ifdef AHB_SUB_WAITSTATE_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Captured address-phase information; meaningful only once a transfer is accepted.
   always_ff @(posedge HCLK) begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
   end

   // SRAM write commit at the end of the write data phase, lane-masked.
   always_ff @(posedge HCLK) begin
      if (!HRESET && (state_q == S_DATA) && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes[b]) begin
               mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule
